// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
    localparam int unsigned IMEM_AW_DEFAULT = 11;

    typedef enum logic {
        RUN,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load; otherwise holds.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            instr_pc <= '0;
            valid    <= 1'b0;
        end else if (bubble) begin
            instr    <= NOP_INSTR;
            instr_pc <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= instr_in;
            instr_pc <= pc_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, redirect/stall/flush control, fetch counter.
// FETCH_MISALIGN_CHECK_EN: misaligned redirect targets trap into a sticky FAULT state.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = IMEM_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic [IMEM_AW-1:0] imem_address,
    input  logic [31:0]        imem_read_data,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc,
    output logic               if_id_valid,
    output logic [31:0]        pc,
    output logic [31:0]        fetch_count,
    output logic               fetch_fault
);

    fetch_state_t state;
    logic         running;
    logic         advance;
    logic         load;
    logic         bubble;
    logic         misaligned;

    assign imem_address = pc[IMEM_AW+1:2];
    assign running      = (state == RUN);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = redirect_target[1:0] != 2'b00;
`else
    assign misaligned = 1'b0;
`endif

    // Priority: redirect > stall > flush > normal advance.
    assign advance = running && !redirect_valid && !stall;
    assign load    = advance && !flush;
    assign bubble  = running && (redirect_valid || (!stall && flush));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else if (running) begin
            if (redirect_valid) begin
                if (misaligned) begin
                    state <= FAULT;
                end else begin
                    pc <= redirect_target & 32'hFFFF_FFFC;
                end
            end else if (!stall) begin
                pc <= pc + 32'd4;
                if (!flush) begin
                    fetch_count <= fetch_count + 32'd1;
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_fault <= 1'b0;
        end else if (running && redirect_valid && misaligned) begin
            fetch_fault <= 1'b1;
        end
    end
`else
    assign fetch_fault = 1'b0;
`endif

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .bubble   (bubble),
        .instr_in (imem_read_data),
        .pc_in    (pc),
        .instr    (if_id_instr),
        .instr_pc (if_id_pc),
        .valid    (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a behavioural fetch model.
module tb_fetch_unit;

    localparam int unsigned AW    = 11;
    localparam int unsigned WORDS = 2048;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          flush;
    logic          redirect_valid;
    logic [31:0]   redirect_target;
    logic [AW-1:0] imem_address;
    logic [31:0]   imem_read_data;
    logic [31:0]   if_id_instr;
    logic [31:0]   if_id_pc;
    logic          if_id_valid;
    logic [31:0]   pc;
    logic [31:0]   fetch_count;
    logic          fetch_fault;

    logic [31:0] mem [WORDS];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_ipc, m_count;
    logic        m_valid, m_fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_read_data = mem[imem_address];

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_address    (imem_address),
        .imem_read_data  (imem_read_data),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .pc              (pc),
        .fetch_count     (fetch_count),
        .fetch_fault     (fetch_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = NOP;
        m_ipc   = 32'h0;
        m_valid = 1'b0;
        m_count = 32'h0;
        m_fault = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = NOP;
        m_ipc   = 32'h0;
        m_valid = 1'b0;
    endtask

    // One rising edge of the fetch rules, evaluated with the current inputs.
    task automatic model_edge();
        if (m_fault) return;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_target % 4 != 0) begin
                m_fault = 1'b1;
                model_bubble();
                return;
            end
`endif
            m_pc = (redirect_target / 4) * 4;
            model_bubble();
        end else if (stall) begin
            // everything holds
        end else if (flush) begin
            m_pc = m_pc + 4;
            model_bubble();
        end else begin
            m_instr = mem[(m_pc / 4) % WORDS];
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 4;
            m_count = m_count + 1;
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".pc"},          pc,                    m_pc);
        check({ctx, ".imem_address"}, 32'(imem_address),    (m_pc / 4) % WORDS);
        check({ctx, ".if_id_instr"}, if_id_instr,           m_instr);
        check({ctx, ".if_id_pc"},    if_id_pc,              m_ipc);
        check({ctx, ".if_id_valid"}, 32'(if_id_valid),      32'(m_valid));
        check({ctx, ".fetch_count"}, fetch_count,           m_count);
        check({ctx, ".fetch_fault"}, 32'(fetch_fault),      32'(m_fault));
    endtask

    task automatic step(input logic st, input logic fl, input logic rv,
                        input logic [31:0] tgt, input string ctx);
        stall           = st;
        flush           = fl;
        redirect_valid  = rv;
        redirect_target = tgt;
        model_edge();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall           = 1'($urandom);
            flush           = 1'($urandom);
            redirect_valid  = 1'($urandom);
            redirect_target = $urandom;
            @(posedge clk);
            #1;
        end
        model_reset();
        check_all("reset");
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        model_reset();

        // Reset with random inputs, then five free-running fetches
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "seq");
        check("seq.count5", fetch_count, 32'd5);
        check("seq.last_pc", if_id_pc, 32'd16);
        check("seq.last_instr", if_id_instr, mem[4]);

        // Stall at pc = 8 for 3 cycles, then release
        step(0, 0, 1, 32'h8, "redir8");
        step(0, 0, 0, 0, "pc8_first");
        step(0, 0, 1, 32'h8, "redir8b");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "stall");
        check("stall.pc_held", pc, 32'h8);
        step(0, 0, 0, 0, "stall_release");
        check("stall.release_pc", if_id_pc, 32'h8);

        // Redirect wins over simultaneous stall
        step(1, 1, 1, 32'h50, "redir_stall");
        check("redir.pc", pc, 32'h50);
        check("redir.bubble", 32'(if_id_valid), 32'd0);
        step(0, 0, 0, 0, "redir_target");
        check("redir.instr", if_id_instr, mem[20]);
        check("redir.ipc", if_id_pc, 32'h50);

        // Flush: PC advances, IF/ID squashed, count held
        step(0, 1, 0, 0, "flush");

        // Address wrap at the top of the instruction memory
        step(0, 0, 1, 32'h1FFC, "wrap_redir");
        step(0, 0, 0, 0, "wrap_a");
        check("wrap.ipc", if_id_pc, 32'h1FFC);
        check("wrap.addr0", 32'(imem_address), 32'd0);
        check("wrap.pc", pc, 32'h2000);
        step(0, 0, 0, 0, "wrap_b");

        // Reset asserted mid-stall takes effect without a clock edge
        stall = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;

        // Randomised mix of stalls, flushes and aligned/unaligned redirects
        for (int i = 0; i < 300; i++) begin
            logic rv;
            rv  = ($urandom_range(0, 7) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h3FFF);
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            step(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0), rv, tgt, "rand");
        end

        // Misaligned redirect
        step(0, 0, 1, 32'h52, "misalign");
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misalign.fault", 32'(fetch_fault), 32'd1);
`else
        check("misalign.pc", pc, 32'h50);
`endif
        for (int i = 0; i < 6; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), $urandom & 32'h1FFC, "after_misalign");

        do_reset();
        step(0, 0, 0, 0, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
